// File: rtl/im_pkg.sv
// Shared types and constants for the loadable LEGLite instruction memory.
package im_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } im_state_t;

  localparam logic [16:0] IM_NOP_WORD = 17'd0;

  // LEGLite opcodes, used when building programs to load
  localparam logic [3:0] OP_LW   = 4'd3;
  localparam logic [3:0] OP_SW   = 4'd4;
  localparam logic [3:0] OP_BEQ  = 4'd5;
  localparam logic [3:0] OP_ADDI = 4'd6;
  localparam logic [3:0] OP_ANDI = 4'd7;
  localparam logic [3:0] OP_J    = 4'd8;

  typedef struct packed {
    logic [3:0] opcode;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [6:0] imm;
  } leg_instr_t;

endpackage

// File: rtl/im_store.sv
// Program word array: synchronous write, indexed combinational read.
// With IM_PARITY_EN each word carries an even-parity bit checked on read.
module im_store #(
  parameter int unsigned DATA_W     = 17,
  parameter int unsigned DEPTH_LOG2 = 5
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
`ifdef IM_PARITY_EN
  ,
  input  logic                  par_inject,
  output logic                  par_err_c
`endif
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

`ifdef IM_PARITY_EN
  localparam int unsigned SW = DATA_W + 1;
`else
  localparam int unsigned SW = DATA_W;
`endif

  logic [SW-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
`ifdef IM_PARITY_EN
      mem[waddr] <= {(^wdata) ^ par_inject, wdata};
`else
      mem[waddr] <= wdata;
`endif
    end
  end

  assign rdata = mem[raddr][DATA_W-1:0];

`ifdef IM_PARITY_EN
  // Odd total parity over data plus stored bit flags a corrupted word
  assign par_err_c = ^mem[raddr];
`endif

endmodule

// File: rtl/im_loadable.sv
// Run-time loadable instruction memory with registered fetch port and stall hold.
// Optional IM_PARITY_EN adds per-word parity with par_err/par_inject ports.
module im_loadable
  import im_pkg::*;
#(
  parameter int unsigned       DATA_W     = 17,
  parameter int unsigned       ADDR_W     = 16,
  parameter int unsigned       DEPTH_LOG2 = 5,
  parameter logic [DATA_W-1:0] NOP_WORD   = DATA_W'(IM_NOP_WORD)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     iaddr,
  input  logic                  fetch_en,
  output logic [DATA_W-1:0]     idata,
  output logic                  ivalid,
  output logic                  addr_err,
  input  logic                  ld_start,
  input  logic                  ld_valid,
  input  logic [DATA_W-1:0]     ld_data,
  input  logic                  ld_last,
  output logic                  ld_ready,
  output logic                  ld_busy,
  output logic [DEPTH_LOG2:0]   ld_count
`ifdef IM_PARITY_EN
  ,
  input  logic                  par_inject,
  output logic                  par_err
`endif
);

  localparam int unsigned CW = DEPTH_LOG2 + 1;

  im_state_t             state, state_d;
  logic [DEPTH_LOG2-1:0] wptr, wptr_d, raddr;
  logic [CW-1:0]         count_d;
  logic [DATA_W-1:0]     idata_d, rdata;
  logic                  ivalid_d, addr_err_d, we, bad_addr;
`ifdef IM_PARITY_EN
  logic                  par_err_d, par_bad;
`endif

  assign raddr    = iaddr[DEPTH_LOG2:1];
  assign bad_addr = iaddr[0] | (|iaddr[ADDR_W-1:DEPTH_LOG2+1]);
  assign ld_busy  = (state == ST_LOAD);
  assign ld_ready = (state == ST_LOAD);

  im_store #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_store (
    .clock (clock),
    .we    (we),
    .waddr (wptr),
    .wdata (ld_data),
    .raddr (raddr),
    .rdata (rdata)
`ifdef IM_PARITY_EN
    ,
    .par_inject (par_inject),
    .par_err_c  (par_bad)
`endif
  );

  // Next-state, load pointer and fetch register values
  always_comb begin
    state_d    = state;
    wptr_d     = wptr;
    count_d    = ld_count;
    idata_d    = idata;
    ivalid_d   = ivalid;
    addr_err_d = addr_err;
    we         = 1'b0;
`ifdef IM_PARITY_EN
    par_err_d  = par_err;
`endif

    if (ld_start) begin
      state_d = ST_LOAD;
      wptr_d  = '0;
      count_d = '0;
    end else if (state == ST_LOAD && ld_valid) begin
      we      = 1'b1;
      count_d = CW'(ld_count + CW'(1));
      if (ld_last || (&wptr)) state_d = ST_RUN;
      // Pointer saturates at the top word; a full load never wraps
      if (!(&wptr)) wptr_d = DEPTH_LOG2'(wptr + DEPTH_LOG2'(1));
    end

    if (fetch_en) begin
`ifdef IM_PARITY_EN
      par_err_d = 1'b0;
`endif
      if (state != ST_RUN) begin
        idata_d    = NOP_WORD;
        ivalid_d   = 1'b0;
        addr_err_d = 1'b0;
      end else if (bad_addr) begin
        idata_d    = NOP_WORD;
        ivalid_d   = 1'b1;
        addr_err_d = 1'b1;
      end else begin
        idata_d    = rdata;
        ivalid_d   = 1'b1;
        addr_err_d = 1'b0;
`ifdef IM_PARITY_EN
        if (par_bad) begin
          idata_d   = NOP_WORD;
          par_err_d = 1'b1;
        end
`endif
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_EMPTY;
      wptr     <= '0;
      ld_count <= '0;
      idata    <= NOP_WORD;
      ivalid   <= 1'b0;
      addr_err <= 1'b0;
`ifdef IM_PARITY_EN
      par_err  <= 1'b0;
`endif
    end else begin
      state    <= state_d;
      wptr     <= wptr_d;
      ld_count <= count_d;
      idata    <= idata_d;
      ivalid   <= ivalid_d;
      addr_err <= addr_err_d;
`ifdef IM_PARITY_EN
      par_err  <= par_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_im_loadable.sv
// Directed bench for im_loadable: load, fetch, stall, address errors, restart, full-depth load.
// Parity vectors run only when IM_PARITY_EN is defined.
module tb_im_loadable;
  import im_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] iaddr = '0;
  logic        fetch_en = 1'b0;
  logic [16:0] idata;
  logic        ivalid, addr_err;
  logic        ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
  logic [16:0] ld_data = '0;
  logic        ld_ready, ld_busy;
  logic [5:0]  ld_count;
`ifdef IM_PARITY_EN
  logic        par_inject = 1'b0;
  logic        par_err;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  logic [16:0] prog [32];
  logic [16:0] part [4];

  im_loadable dut (
    .clock    (clock),
    .reset    (reset),
    .iaddr    (iaddr),
    .fetch_en (fetch_en),
    .idata    (idata),
    .ivalid   (ivalid),
    .addr_err (addr_err),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .ld_ready (ld_ready),
    .ld_busy  (ld_busy),
    .ld_count (ld_count)
`ifdef IM_PARITY_EN
    ,
    .par_inject (par_inject),
    .par_err    (par_err)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input logic [15:0] a);
    iaddr    = a;
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
  endtask

  task automatic put(input logic [16:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic start();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) prog[i] = {OP_SW, 3'(i), 3'(i + 1), 7'(i * 3)};
    prog[0]  = 17'h0C101;  // addi: opcode 6, rs 0, rt 2, imm 1
    prog[14] = 17'h0A503;  // beq: opcode 5, rs 1, rt 2, imm 3
    part[0] = 17'h11111; part[1] = 17'h02222; part[2] = 17'h13333; part[3] = 17'h04444;

    tick(); tick();
    chk("rst_idata", 32'(idata), 32'h0);
    chk("rst_ivalid", 32'(ivalid), 32'h0);
    chk("rst_addr_err", 32'(addr_err), 32'h0);
    chk("rst_busy", 32'(ld_busy), 32'h0);
    chk("rst_ready", 32'(ld_ready), 32'h0);
    chk("rst_count", 32'(ld_count), 32'h0);
    reset = 1'b0;
    tick();

    fetch(16'd0);
    chk("empty_idata", 32'(idata), 32'h0);
    chk("empty_ivalid", 32'(ivalid), 32'h0);
    chk("empty_addr_err", 32'(addr_err), 32'h0);

    start();
    chk("load_busy", 32'(ld_busy), 32'h1);
    chk("load_ready", 32'(ld_ready), 32'h1);
    fetch(16'd0);
    chk("load_fetch_ivalid", 32'(ivalid), 32'h0);
    for (int i = 0; i < 15; i++) put(prog[i], i == 14);
    chk("p15_count", 32'(ld_count), 32'd15);
    chk("p15_busy", 32'(ld_busy), 32'h0);
    chk("p15_ready", 32'(ld_ready), 32'h0);

    fetch(16'd0);
    chk("run_w0", 32'(idata), 32'h0C101);
    chk("run_w0_ivalid", 32'(ivalid), 32'h1);
    chk("run_w0_addr_err", 32'(addr_err), 32'h0);

    fetch(16'd28);
    chk("run_w14", 32'(idata), 32'h0A503);
    iaddr = 16'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold", 32'(idata), 32'h0A503);
    end
    chk("stall_ivalid", 32'(ivalid), 32'h1);

    fetch(16'd3);
    chk("misalign_err", 32'(addr_err), 32'h1);
    chk("misalign_idata", 32'(idata), 32'h0);
    chk("misalign_ivalid", 32'(ivalid), 32'h1);
    fetch(16'h0040);
    chk("range_err", 32'(addr_err), 32'h1);
    fetch(16'd2);
    chk("run_w1", 32'(idata), 32'(prog[1]));
    chk("run_w1_err", 32'(addr_err), 32'h0);

    // Restart mid-load; the word presented with ld_start must be dropped
    start();
    for (int i = 0; i < 4; i++) put(part[i], 1'b0);
    chk("partial_count", 32'(ld_count), 32'd4);
    ld_start = 1'b1; ld_valid = 1'b1; ld_data = 17'h1FFFF;
    tick();
    ld_start = 1'b0; ld_valid = 1'b0;
    chk("restart_count", 32'(ld_count), 32'd0);
    chk("restart_busy", 32'(ld_busy), 32'h1);
    put(17'h1ABCD, 1'b0);
    put(17'h00F0F, 1'b1);
    chk("reload_count", 32'(ld_count), 32'd2);
    chk("reload_busy", 32'(ld_busy), 32'h0);
    fetch(16'd0);
    chk("reload_w0", 32'(idata), 32'h1ABCD);
    fetch(16'd2);
    chk("reload_w1", 32'(idata), 32'h00F0F);
    fetch(16'd6);
    chk("stale_w3", 32'(idata), 32'h04444);
    fetch(16'd8);
    chk("dropped_w4", 32'(idata), 32'(prog[4]));

    // Full-depth load without ld_last saturates and exits
    start();
    for (int i = 0; i < 31; i++) put(17'h10000 | 17'(i), 1'b0);
    chk("fd31_count", 32'(ld_count), 32'd31);
    chk("fd31_ready", 32'(ld_ready), 32'h1);
    put(17'h1001F, 1'b0);
    chk("fd32_count", 32'(ld_count), 32'd32);
    chk("fd32_ready", 32'(ld_ready), 32'h0);
    chk("fd32_busy", 32'(ld_busy), 32'h0);
    put(17'h0AAAA, 1'b0);
    chk("fd33_count", 32'(ld_count), 32'd32);
    fetch(16'd62);
    chk("fd_w31", 32'(idata), 32'h1001F);
    fetch(16'd0);
    chk("fd_w0", 32'(idata), 32'h10000);

    // Reset during a load returns to the empty state
    start();
    put(17'h15555, 1'b0);
    reset = 1'b1;
    #2;
    chk("rstmid_busy", 32'(ld_busy), 32'h0);
    chk("rstmid_count", 32'(ld_count), 32'h0);
    tick();
    reset = 1'b0;
    tick();
    fetch(16'd0);
    chk("rstmid_ivalid", 32'(ivalid), 32'h0);
    chk("rstmid_idata", 32'(idata), 32'h0);

`ifdef IM_PARITY_EN
    start();
    for (int i = 0; i < 6; i++) begin
      par_inject = (i == 5);
      put(prog[i], i == 5);
    end
    par_inject = 1'b0;
    fetch(16'd10);
    chk("par_bad_err", 32'(par_err), 32'h1);
    chk("par_bad_idata", 32'(idata), 32'h0);
    fetch(16'd8);
    chk("par_ok_err", 32'(par_err), 32'h0);
    chk("par_ok_idata", 32'(idata), 32'(prog[4]));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/im_loadable.md
Name: im_loadable

Overview:
- Parametrised successor to the fixed-program instruction memory of the LEGLite pipeline.
- Holds a RAM-backed program of DATA_W-bit instructions indexed by byte address, and provides a registered fetch port with a stall hold for the pipelined CPU.
- Adds a streaming program-load port, so test programs are loaded at run time instead of being hard-coded.
- Sits between the IF stage and an external loader (testbench or UART bootloader).

Parameters:
- DATA_W, 17, instruction width (4-bit opcode + 13-bit field).
- ADDR_W, 16, CPU address width.
- DEPTH_LOG2, 5, log2 of the word count (32 words).
- NOP_WORD, 17'd0, word returned when no valid instruction is available.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- iaddr  in  ADDR_W  byte address from the PC; word index = iaddr[DEPTH_LOG2:1].
- fetch_en  in  1  1 = fetch this cycle; 0 = stall, outputs hold.
- idata  out  DATA_W  registered instruction.
- ivalid  out  1  idata is a real program word.
- addr_err  out  1  registered; the last fetch was misaligned or out of range.
- ld_start  in  1  pulse: begin or restart a program load.
- ld_valid  in  1  ld_data is valid.
- ld_data  in  DATA_W  program word to store.
- ld_last  in  1  qualifies the final word of the program.
- ld_ready  out  1  the block accepts a word this cycle.
- ld_busy  out  1  a load is in progress.
- ld_count  out  DEPTH_LOG2+1  number of words stored by the current or last load.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: idata=NOP_WORD, ivalid=0, addr_err=0, ld_ready=0, ld_busy=0, ld_count=0, write pointer=0, state=EMPTY. Memory contents are not reset.
- State EMPTY (no program loaded):
  - Fetches load idata=NOP_WORD with ivalid=0.
  - ld_start -> LOAD.
- State LOAD:
  - ld_busy=1 and ld_ready=1 (combinational from state).
  - Each cycle with ld_valid=1 writes mem[wptr]=ld_data, then increments wptr and ld_count.
  - A write with ld_last=1, or a write at wptr=2^DEPTH_LOG2-1, ends the load: -> RUN on the next edge.
  - A full-depth load without ld_last is legal and saturates; it does not wrap.
  - Fetches during LOAD give idata=NOP_WORD, ivalid=0.
- ld_start in any state:
  - Sets wptr=0 and ld_count=0, and goes to LOAD.
  - Takes priority over a simultaneous ld_valid: that word is dropped.
  - Restarting mid-load discards the partial load. Words already written stay in memory but are overwritten as the new load proceeds.
- State RUN:
  - On fetch_en=1, the next edge loads idata=mem[iaddr[DEPTH_LOG2:1]], sets ivalid=1, and sets addr_err=0 (one-cycle latency).
  - If iaddr[0]=1, or any bit of iaddr[ADDR_W-1:DEPTH_LOG2+1] is nonzero: idata=NOP_WORD, ivalid=1, addr_err=1.
- fetch_en=0 in any state: idata, ivalid and addr_err hold their values.
- Reads of words at or above ld_count in RUN return whatever the memory holds; no protection.
- No read-during-write hazard: fetches are blocked while in LOAD.
- Reset mid-load: back to EMPTY, and the program is treated as absent.

Optional Feature:
- IM_PARITY_EN, when defined:
  - Each stored word carries an extra even-parity bit, computed on write.
  - Adds output par_err (1 bit, reset 0), registered on each RUN fetch.
  - On a parity mismatch: par_err=1 and idata=NOP_WORD.
  - Adds input par_inject (1 bit): while high, written words store inverted parity (test only).
- When undefined: no parity storage, and no par_err or par_inject ports.

Decomposition:
- Package im_pkg:
  - State encoding: EMPTY, LOAD, RUN.
  - NOP_WORD default.
  - LEGLite opcode constants (ADDI=6, SW=4, LW=3, BEQ=5, ANDI=7, J=8), used by benches to build programs.
- One sub-module, im_store: the memory array, with a synchronous write port and an indexed read port, plus the parity bit under IM_PARITY_EN.
- The FSM, pointers and output registers live in the top module.

Test Plan:
- Reset, then fetch iaddr=0 -> idata=0, ivalid=0, addr_err=0. ld_busy=0.
- ld_start, then stream 15 words (word 0 = {4'd6,3'd0,3'd2,7'd1}), ld_last on the 15th -> ld_count=15, state RUN. Fetch iaddr=0 -> next cycle idata=17'h0C101 (opcode 6, rs 0, rt 2, imm 1), ivalid=1.
- In RUN: fetch iaddr=28 gives word 14, then hold fetch_en=0 for 3 cycles -> idata stays word 14. Fetch iaddr=3 -> addr_err=1, idata=0. Fetch iaddr=16'h0040 -> addr_err=1.
- Mid-load restart: ld_start after 4 words, with ld_valid high the same cycle -> that word dropped, ld_count=0. Then reload 2 words -> ld_count=2, mem[0..1] hold the new data.
- Full-depth load: 32 words without ld_last -> exits to RUN after word 31, ld_count=32, ld_ready=0. A 33rd ld_valid is ignored.
- With IM_PARITY_EN: load word 5 with par_inject=1, then fetch iaddr=10 -> par_err=1, idata=0. Fetch iaddr=8 -> par_err=0.
